// File: rtl/mips_defs.sv
// mips_defs: shared ALU opcode, MIPS opcode/funct encodings and ID/EX register layout.
package mips_defs;
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_PASSB = 4'b0011;
  localparam logic [3:0] OP_SLLV  = 4'b0100;
  localparam logic [3:0] OP_SRLV  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SRAV  = 4'b1000;
  localparam logic [3:0] OP_XOR   = 4'b1001;
  localparam logic [3:0] OP_NOR   = 4'b1010;
  localparam logic [3:0] OP_SLT   = 4'b1011;
  localparam logic [3:0] OP_SLTU  = 4'b1100;
  localparam logic [3:0] OP_SLL   = 4'b1101;
  localparam logic [3:0] OP_SRL   = 4'b1110;
  localparam logic [3:0] NOP_OP   = OP_PASSB;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {IMM_SEXT, IMM_ZEXT, IMM_LUI} imm_sel_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  s;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic        illegal;
  } ex_reg_t;

  localparam ex_reg_t EX_BUBBLE = '{valid: 1'b0, a: '0, b: '0, op: NOP_OP, s: '0,
                                    wr_en: 1'b0, wr_reg: '0, illegal: 1'b0};
  localparam ex_reg_t EX_ILLEGAL = '{valid: 1'b1, a: '0, b: '0, op: NOP_OP, s: '0,
                                     wr_en: 1'b0, wr_reg: '0, illegal: 1'b1};
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational map from instruction word to ALU op, shamt, operand-B select and destination.
module alu_op_decode
  import mips_defs::*;
(
  input  logic [31:0] i_instr,
  output logic [3:0]  o_op,
  output logic [4:0]  o_s,
  output imm_sel_t    o_imm_sel,
  output logic        o_b_sel,
  output logic        o_wr_en,
  output logic [4:0]  o_wr_reg,
  output logic        o_illegal
);
  logic [5:0] w_opc;
  logic [5:0] w_fn;
  logic [4:0] w_dst;
  logic       w_wr;
  logic       w_unused_rs;
  assign w_opc       = i_instr[31:26];
  assign w_fn        = i_instr[5:0];
  assign w_unused_rs = ^i_instr[25:21];
  always_comb begin
    o_op      = NOP_OP;
    o_s       = '0;
    o_imm_sel = IMM_SEXT;
    o_b_sel   = 1'b1;
    o_illegal = 1'b0;
    w_dst     = i_instr[20:16];
    w_wr      = 1'b1;
    case (w_opc)
      OPC_RTYPE: begin
        o_b_sel = 1'b0;
        w_dst   = i_instr[15:11];
        case (w_fn)
          FN_SLL:          begin o_op = OP_SLL; o_s = i_instr[10:6]; end
          FN_SRL:          begin o_op = OP_SRL; o_s = i_instr[10:6]; end
          FN_SRA:          begin o_op = OP_SRA; o_s = i_instr[10:6]; end
          FN_SLLV:         o_op = OP_SLLV;
          FN_SRLV:         o_op = OP_SRLV;
          FN_SRAV:         o_op = OP_SRAV;
          FN_ADD, FN_ADDU: o_op = OP_ADD;
          FN_SUB, FN_SUBU: o_op = OP_SUB;
          FN_AND:          o_op = OP_AND;
          FN_OR:           o_op = OP_OR;
          FN_XOR:          o_op = OP_XOR;
          FN_NOR:          o_op = OP_NOR;
          FN_SLT:          o_op = OP_SLT;
          FN_SLTU:         o_op = OP_SLTU;
          default:         o_illegal = 1'b1;
        endcase
      end
      OPC_ADDI, OPC_ADDIU, OPC_LW: o_op = OP_ADD;
      OPC_SW:                      begin o_op = OP_ADD; w_wr = 1'b0; end
      OPC_SLTI:                    o_op = OP_SLT;
      OPC_SLTIU:                   o_op = OP_SLTU;
      OPC_ANDI:                    begin o_op = OP_AND; o_imm_sel = IMM_ZEXT; end
      OPC_ORI:                     begin o_op = OP_OR;  o_imm_sel = IMM_ZEXT; end
      OPC_XORI:                    begin o_op = OP_XOR; o_imm_sel = IMM_ZEXT; end
      OPC_LUI:                     begin o_op = OP_PASSB; o_imm_sel = IMM_LUI; end
      OPC_BEQ, OPC_BNE:            begin o_op = OP_SUB; o_b_sel = 1'b0; w_wr = 1'b0; end
      default:                     o_illegal = 1'b1;
    endcase
  end
  // Reserved encodings collapse to bubble values; writes to $0 are suppressed.
  assign o_wr_reg = o_illegal ? '0 : w_dst;
  assign o_wr_en  = w_wr & ~o_illegal & (w_dst != '0);
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX boundary - decodes the ID instruction and registers the ALU operand/opcode bundle.
module alu_issue_stage
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] ex_A,
  output logic [31:0] ex_B,
  output logic [3:0]  ex_Op,
  output logic [4:0]  ex_s,
  output logic        ex_wr_en,
  output logic [4:0]  ex_wr_reg,
  output logic        ex_illegal
);
  logic [3:0]  w_op;
  logic [4:0]  w_s;
  imm_sel_t    w_imm_sel;
  logic        w_b_sel;
  logic        w_wr_en;
  logic [4:0]  w_wr_reg;
  logic        w_illegal;
  logic [15:0] w_imm;
  logic [31:0] w_imm_ext;
  logic [31:0] w_a;
  logic [31:0] w_b;
  ex_reg_t     w_load;
  ex_reg_t     w_next;
  ex_reg_t     r_ex;

  alu_op_decode u_dec (
    .i_instr   (id_instr),
    .o_op      (w_op),
    .o_s       (w_s),
    .o_imm_sel (w_imm_sel),
    .o_b_sel   (w_b_sel),
    .o_wr_en   (w_wr_en),
    .o_wr_reg  (w_wr_reg),
    .o_illegal (w_illegal)
  );

  assign w_imm     = id_instr[15:0];
  assign w_imm_ext = (w_imm_sel == IMM_ZEXT) ? {16'h0, w_imm} :
                     (w_imm_sel == IMM_LUI)  ? {w_imm, 16'h0} : {{16{w_imm[15]}}, w_imm};
  assign w_a       = (w_imm_sel == IMM_LUI) ? '0 : id_rs_data;
  assign w_b       = w_b_sel ? w_imm_ext : id_rt_data;
  assign w_load    = w_illegal ? EX_ILLEGAL :
                     '{valid: 1'b1, a: w_a, b: w_b, op: w_op, s: w_s,
                       wr_en: w_wr_en, wr_reg: w_wr_reg, illegal: 1'b0};
  // Flush wins over stall so a squashed instruction never lingers in EX.
  assign w_next    = flush ? EX_BUBBLE : stall ? r_ex : id_valid ? w_load : EX_BUBBLE;

  always_ff @(posedge clk or posedge reset)
    if (reset) r_ex <= EX_BUBBLE;
    else       r_ex <= w_next;

  assign ex_valid   = r_ex.valid;
  assign ex_A       = r_ex.a;
  assign ex_B       = r_ex.b;
  assign ex_Op      = r_ex.op;
  assign ex_s       = r_ex.s;
  assign ex_wr_en   = r_ex.wr_en;
  assign ex_wr_reg  = r_ex.wr_reg;
  assign ex_illegal = r_ex.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors with hand-computed expectations for alu_issue_stage.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        reset, id_valid, stall, flush;
  logic [31:0] id_instr, id_rs_data, id_rt_data;
  logic        ex_valid, ex_wr_en, ex_illegal;
  logic [31:0] ex_A, ex_B;
  logic [3:0]  ex_Op;
  logic [4:0]  ex_s, ex_wr_reg;
  int          vectors = 0;
  int          errors = 0;

  alu_issue_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_Op(ex_Op), .ex_s(ex_s),
    .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_ex(input string tag, input logic v, input logic [31:0] a, b,
                           input logic [3:0] op, input logic [4:0] s, input logic we,
                           input logic [4:0] wr, input logic ill);
    check({tag, ".valid"},   32'(ex_valid),   32'(v));
    check({tag, ".A"},       ex_A,            a);
    check({tag, ".B"},       ex_B,            b);
    check({tag, ".Op"},      32'(ex_Op),      32'(op));
    check({tag, ".s"},       32'(ex_s),       32'(s));
    check({tag, ".wr_en"},   32'(ex_wr_en),   32'(we));
    check({tag, ".wr_reg"},  32'(ex_wr_reg),  32'(wr));
    check({tag, ".illegal"}, 32'(ex_illegal), 32'(ill));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] rs, rt);
    id_instr = instr; id_rs_data = rs; id_rt_data = rt;
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(itype(6'h08, 5'd3, 5'd5, 16'hFFFC), 32'h10, 32'h0);
    #1;
    expect_ex("rst_async", 0, 0, 0, 4'b0011, 0, 0, 0, 0);
    cyc(); cyc();
    expect_ex("rst_held", 0, 0, 0, 4'b0011, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    expect_ex("rst_release", 0, 0, 0, 4'b0011, 0, 0, 0, 0);
    cyc();
    expect_ex("addi", 1, 32'h10, 32'hFFFFFFFC, 4'b0010, 0, 1, 5, 0);

    drive(itype(6'h0D, 5'd1, 5'd2, 16'h8000), 32'hAAAA0000, 32'h0);
    cyc();
    expect_ex("ori", 1, 32'hAAAA0000, 32'h00008000, 4'b0001, 0, 1, 2, 0);
    drive(itype(6'h0F, 5'd0, 5'd7, 16'h1234), 32'hDEADBEEF, 32'h0);
    cyc();
    expect_ex("lui", 1, 0, 32'h12340000, 4'b0011, 0, 1, 7, 0);

    drive(rtype(5'd0, 5'd6, 5'd4, 5'd7, 6'h03), 32'h55, 32'h80000000);
    cyc();
    expect_ex("sra", 1, 32'h55, 32'h80000000, 4'b0111, 7, 1, 4, 0);
    drive(rtype(5'd5, 5'd6, 5'd4, 5'd0, 6'h07), 32'h3, 32'h80000000);
    cyc();
    expect_ex("srav", 1, 32'h3, 32'h80000000, 4'b1000, 0, 1, 4, 0);

    drive(rtype(5'd9, 5'd10, 5'd8, 5'd0, 6'h22), 32'h100, 32'h30);
    cyc();
    expect_ex("sub", 1, 32'h100, 32'h30, 4'b0110, 0, 1, 8, 0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(itype(6'h0D, 5'(i), 5'(i + 1), 16'(i)), 32'(i), 32'(i * 7));
      cyc();
      expect_ex($sformatf("stall%0d", i), 1, 32'h100, 32'h30, 4'b0110, 0, 1, 8, 0);
    end
    flush = 1'b1;
    cyc();
    expect_ex("stall_flush", 0, 0, 0, 4'b0011, 0, 0, 0, 0);
    stall = 1'b0; flush = 1'b0;

    drive({6'h3F, 26'h1234567}, 32'h11, 32'h22);
    cyc();
    expect_ex("illegal_opc", 1, 0, 0, 4'b0011, 0, 0, 0, 1);
    drive(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h24), 32'hF0F0, 32'h0FF0);
    cyc();
    expect_ex("and_clears", 1, 32'hF0F0, 32'h0FF0, 4'b0000, 0, 1, 3, 0);
    drive(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F), 32'h1, 32'h2);
    cyc();
    expect_ex("illegal_fn", 1, 0, 0, 4'b0011, 0, 0, 0, 1);
    drive(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h21), 32'h1, 32'h2);
    cyc();
    expect_ex("addu_r0", 1, 32'h1, 32'h2, 4'b0010, 0, 0, 0, 0);
    drive(32'h0, 32'h0, 32'h0);
    cyc();
    expect_ex("nop", 1, 0, 0, 4'b1101, 0, 0, 0, 0);

    drive(itype(6'h2B, 5'd4, 5'd9, 16'h8010), 32'h1000, 32'h77);
    cyc();
    expect_ex("sw", 1, 32'h1000, 32'hFFFF8010, 4'b0010, 0, 0, 9, 0);
    drive(itype(6'h0B, 5'd4, 5'd9, 16'h8000), 32'h5, 32'h77);
    cyc();
    expect_ex("sltiu", 1, 32'h5, 32'hFFFF8000, 4'b1100, 0, 1, 9, 0);
    drive(itype(6'h0E, 5'd4, 5'd9, 16'hFFFF), 32'h5, 32'h77);
    cyc();
    expect_ex("xori", 1, 32'h5, 32'h0000FFFF, 4'b1001, 0, 1, 9, 0);
    drive(itype(6'h04, 5'd4, 5'd9, 16'h0010), 32'h8, 32'h3);
    cyc();
    check("beq.Op", 32'(ex_Op), 32'h6);
    check("beq.B", ex_B, 32'h3);
    check("beq.wr_en", 32'(ex_wr_en), 32'h0);
    drive(rtype(5'd0, 5'd3, 5'd12, 5'd31, 6'h00), 32'h0, 32'h1);
    cyc();
    expect_ex("sll31", 1, 32'h0, 32'h1, 4'b1101, 31, 1, 12, 0);

    id_valid = 1'b0;
    cyc();
    expect_ex("invalid", 0, 0, 0, 4'b0011, 0, 0, 0, 0);

    id_valid = 1'b1;
    drive(itype(6'h09, 5'd2, 5'd6, 16'h0004), 32'h20, 32'h0);
    cyc();
    stall = 1'b1;
    cyc();
    expect_ex("pre_rst_stall", 1, 32'h20, 32'h4, 4'b0010, 0, 1, 6, 0);
    reset = 1'b1;
    #1;
    expect_ex("rst_mid_stall", 0, 0, 0, 4'b0011, 0, 0, 0, 0);
    cyc();
    reset = 1'b0;
    cyc();
    expect_ex("post_rst_stall", 0, 0, 0, 4'b0011, 0, 0, 0, 0);
    stall = 1'b0;
    cyc();
    expect_ex("post_rst_load", 1, 32'h20, 32'h4, 4'b0010, 0, 1, 6, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
